// File: rtl/exc_ctrl_pkg.sv
// Shared constants and types for the exception/interrupt commit controller:
// cp0 addresses, ExcCodes, Status/Cause field indices and FSM encoding.
package exc_ctrl_pkg;

    localparam logic [31:0] ENTRY_BEV1_DEF = 32'hBFC0_0380;
    localparam logic [31:0] ENTRY_BEV0_DEF = 32'h8000_0180;

    // cp0 addresses are {reg[4:0], sel[2:0]}
    localparam logic [7:0] CP0_STATUS = 8'h60;
    localparam logic [7:0] CP0_CAUSE  = 8'h68;
    localparam logic [7:0] CP0_EPC    = 8'h70;

    localparam logic [4:0] EXC_INT_DEF = 5'h00;
    localparam logic [4:0] EXC_ADEL    = 5'h04;
    localparam logic [4:0] EXC_ADES    = 5'h05;
    localparam logic [4:0] EXC_SYS     = 5'h08;
    localparam logic [4:0] EXC_BP      = 5'h09;
    localparam logic [4:0] EXC_RI      = 5'h0a;
    localparam logic [4:0] EXC_OV      = 5'h0c;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned ST_BEV = 22;
    localparam int unsigned IM_LO  = 8;
    localparam int unsigned IM_HI  = 15;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAIN    = 2'd1,
        S_COMMIT   = 2'd2,
        S_REDIRECT = 2'd3
    } state_e;

    typedef struct packed {
        logic [4:0]  excode;
        logic        bd;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic [31:0] target;
    } cap_t;

    // A delay-slot instruction restarts at its branch.
    function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic bd);
        logic [31:0] r;
        if (bd) begin
            r = pc - 32'd4;
        end else begin
            r = pc;
        end
        return r;
    endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / cp0 / fetch-redirect signal bundle around exc_ctrl.
interface exc_ctrl_if;
    logic        mem_valid;
    logic [31:0] mem_pc;
    logic        mem_bd;
    logic        mem_ex;
    logic [4:0]  mem_excode;
    logic [31:0] mem_badvaddr;
    logic        mem_eret;
    logic        mem_mtc0;
    logic [7:0]  mem_mtc0_addr;
    logic        mem_busy;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic        ex_valid;
    logic [4:0]  ex_excode;
    logic        ex_bd;
    logic [31:0] ex_epc;
    logic [31:0] ex_badvaddr;
    logic        ex_eret;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport slave (
        input  mem_valid, mem_pc, mem_bd, mem_ex, mem_excode, mem_badvaddr,
               mem_eret, mem_mtc0, mem_mtc0_addr, mem_busy,
               cp0_status, cp0_cause, cp0_epc,
        output ex_valid, ex_excode, ex_bd, ex_epc, ex_badvaddr, ex_eret,
               stall, flush, redirect_valid, redirect_pc
    );

    modport master (
        output mem_valid, mem_pc, mem_bd, mem_ex, mem_excode, mem_badvaddr,
               mem_eret, mem_mtc0, mem_mtc0_addr, mem_busy,
               cp0_status, cp0_cause, cp0_epc,
        input  ex_valid, ex_excode, ex_bd, ex_epc, ex_badvaddr, ex_eret,
               stall, flush, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/exc_ctrl_prio.sv
// Combinational interrupt qualification and interrupt > exception > eret
// arbitration; produces the take strobe and the selected ExcCode.
module exc_ctrl_prio
    import exc_ctrl_pkg::*;
#(
    parameter logic [4:0] EXC_INT = EXC_INT_DEF
) (
    input  logic        idle_i,
    input  logic        mem_valid_i,
    input  logic        mem_ex_i,
    input  logic [4:0]  mem_excode_i,
    input  logic        mem_eret_i,
    input  logic        mem_mtc0_i,
    input  logic [7:0]  mem_mtc0_addr_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    output logic        take_o,
    output logic [4:0]  excode_o,
    output logic        eret_o
);

    logic int_block_s;
    logic int_req_s;

    // A Status/Cause write in flight makes the sampled values stale for one cycle.
    always_comb begin
        int_block_s = mem_mtc0_i &
                      ((mem_mtc0_addr_i == CP0_STATUS) | (mem_mtc0_addr_i == CP0_CAUSE));
        int_req_s   = (|(cp0_cause_i[IM_HI:IM_LO] & cp0_status_i[IM_HI:IM_LO])) &
                      cp0_status_i[ST_IE] & ~cp0_status_i[ST_EXL] & ~int_block_s;
        take_o      = idle_i & mem_valid_i & (int_req_s | mem_ex_i | mem_eret_i);
        if (int_req_s) begin
            excode_o = EXC_INT;
        end else begin
            excode_o = mem_excode_i;
        end
        eret_o      = ~int_req_s & ~mem_ex_i & mem_eret_i;
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/eret commit controller: capture on take, drain the data bus,
// pulse cp0 once, then flush and redirect fetch.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] ENTRY_BEV1 = ENTRY_BEV1_DEF,
    parameter logic [31:0] ENTRY_BEV0 = ENTRY_BEV0_DEF,
    parameter logic [4:0]  EXC_INT    = EXC_INT_DEF
) (
    input  logic      clk,
    input  logic      resetn,
    exc_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    cap_t        cap_q, cap_d;
    logic        take_s;
    logic [4:0]  sel_excode_s;
    logic        sel_eret_s;

    logic        ex_valid_q;
    logic [4:0]  ex_excode_q;
    logic        ex_bd_q;
    logic        ex_eret_q;
    logic [31:0] ex_epc_q;
    logic [31:0] ex_badvaddr_q;
    logic        flush_q;
    logic [31:0] redirect_pc_q;

    exc_ctrl_prio #(.EXC_INT(EXC_INT)) u_prio (
        .idle_i          (state_q == S_IDLE),
        .mem_valid_i     (bus.mem_valid),
        .mem_ex_i        (bus.mem_ex),
        .mem_excode_i    (bus.mem_excode),
        .mem_eret_i      (bus.mem_eret),
        .mem_mtc0_i      (bus.mem_mtc0),
        .mem_mtc0_addr_i (bus.mem_mtc0_addr),
        .cp0_status_i    (bus.cp0_status),
        .cp0_cause_i     (bus.cp0_cause),
        .take_o          (take_s),
        .excode_o        (sel_excode_s),
        .eret_o          (sel_eret_s)
    );

    // Next-state and capture selection.
    always_comb begin
        state_d = state_q;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (take_s) begin
                    cap_d.excode   = sel_excode_s;
                    cap_d.eret     = sel_eret_s;
                    cap_d.bd       = bus.mem_bd;
                    cap_d.epc      = restart_pc(bus.mem_pc, bus.mem_bd);
                    cap_d.badvaddr = bus.mem_badvaddr;
                    if (sel_eret_s) begin
                        cap_d.target = bus.cp0_epc;
                    end else if (bus.cp0_status[ST_BEV]) begin
                        cap_d.target = ENTRY_BEV1;
                    end else begin
                        cap_d.target = ENTRY_BEV0;
                    end
                    state_d = bus.mem_busy ? S_DRAIN : S_COMMIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (bus.mem_busy) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT:   state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // State, capture and output registers; outputs are decoded from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            cap_q         <= '0;
            ex_valid_q    <= 1'b0;
            ex_excode_q   <= 5'd0;
            ex_bd_q       <= 1'b0;
            ex_eret_q     <= 1'b0;
            ex_epc_q      <= 32'd0;
            ex_badvaddr_q <= 32'd0;
            flush_q       <= 1'b0;
            redirect_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cap_q      <= cap_d;
            ex_valid_q <= (state_d == S_COMMIT);
            flush_q    <= (state_d == S_REDIRECT);
            if (state_d == S_COMMIT) begin
                ex_excode_q   <= cap_d.excode;
                ex_bd_q       <= cap_d.bd;
                ex_eret_q     <= cap_d.eret;
                ex_epc_q      <= cap_d.epc;
                ex_badvaddr_q <= cap_d.badvaddr;
            end else begin
                ex_excode_q   <= 5'd0;
                ex_bd_q       <= 1'b0;
                ex_eret_q     <= 1'b0;
                ex_epc_q      <= 32'd0;
                ex_badvaddr_q <= 32'd0;
            end
            if (state_d == S_REDIRECT) begin
                redirect_pc_q <= cap_d.target;
            end else begin
                redirect_pc_q <= 32'd0;
            end
        end
    end

    assign bus.stall          = take_s | (state_q == S_DRAIN) | (state_q == S_COMMIT);
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_excode      = ex_excode_q;
    assign bus.ex_bd          = ex_bd_q;
    assign bus.ex_eret        = ex_eret_q;
    assign bus.ex_epc         = ex_epc_q;
    assign bus.ex_badvaddr    = ex_badvaddr_q;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = flush_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected commits/redirects are queued when a
// take is driven and checked when the DUT emits them.
module tb_exc_ctrl;

    typedef struct packed {
        logic [4:0]  excode;
        logic        bd;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] badvaddr;
        logic [31:0] target;
    } exp_t;

    logic clk;
    logic resetn;
    int   n_cmp;
    int   n_err;
    exp_t exq[$];
    logic [31:0] rdq[$];

    exc_ctrl_if bus ();

    exc_ctrl u_dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.mem_valid     = 1'b0;
        bus.mem_pc        = 32'd0;
        bus.mem_bd        = 1'b0;
        bus.mem_ex        = 1'b0;
        bus.mem_excode    = 5'd0;
        bus.mem_badvaddr  = 32'd0;
        bus.mem_eret      = 1'b0;
        bus.mem_mtc0      = 1'b0;
        bus.mem_mtc0_addr = 8'd0;
        bus.mem_busy      = 1'b0;
        bus.cp0_status    = 32'd0;
        bus.cp0_cause     = 32'd0;
        bus.cp0_epc       = 32'd0;
    endtask

    // Inputs already driven for a take; queue expectation, check stall, retire instruction.
    task automatic launch(input exp_t e, input int settle);
        exq.push_back(e);
        rdq.push_back(e.target);
        @(negedge clk);
        chk("take_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        repeat (settle) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.ex_valid) begin
                if (exq.size() == 0) begin
                    chk("ex_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exq.pop_front();
                    chk("ex_excode", {27'd0, bus.ex_excode}, {27'd0, e.excode});
                    chk("ex_bd", {31'd0, bus.ex_bd}, {31'd0, e.bd});
                    chk("ex_eret", {31'd0, bus.ex_eret}, {31'd0, e.eret});
                    chk("ex_epc", bus.ex_epc, e.epc);
                    chk("ex_badvaddr", bus.ex_badvaddr, e.badvaddr);
                    chk("commit_stall", {31'd0, bus.stall}, 32'd1);
                end
            end else begin
                chk("ex_epc_idle", bus.ex_epc, 32'd0);
            end
            if (bus.redirect_valid) begin
                if (rdq.size() == 0) begin
                    chk("redir_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("redirect_pc", bus.redirect_pc, rdq.pop_front());
                    chk("flush", {31'd0, bus.flush}, 32'd1);
                end
            end else begin
                chk("flush_idle", {31'd0, bus.flush}, 32'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_cmp  = 0;
        n_err  = 0;
        resetn = 1'b0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rst_stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;

        // Interrupt, BEV=1
        bus.cp0_status = 32'h0040_0401;
        bus.cp0_cause  = 32'h0000_0400;
        bus.mem_valid  = 1'b1;
        bus.mem_pc     = 32'h8000_1000;
        e = '{excode: 5'h00, bd: 1'b0, eret: 1'b0, epc: 32'h8000_1000,
              badvaddr: 32'h0, target: 32'hBFC0_0380};
        launch(e, 3);

        // AdEL in delay slot, BEV=0
        bus.mem_valid    = 1'b1;
        bus.mem_ex       = 1'b1;
        bus.mem_excode   = 5'h04;
        bus.mem_pc       = 32'h8000_2004;
        bus.mem_bd       = 1'b1;
        bus.mem_badvaddr = 32'h0000_0003;
        e = '{excode: 5'h04, bd: 1'b1, eret: 1'b0, epc: 32'h8000_2000,
              badvaddr: 32'h3, target: 32'h8000_0180};
        launch(e, 3);

        // eret to EPC
        bus.mem_valid = 1'b1;
        bus.mem_eret  = 1'b1;
        bus.mem_pc    = 32'h8000_0200;
        bus.cp0_epc   = 32'h8000_3000;
        e = '{excode: 5'h00, bd: 1'b0, eret: 1'b1, epc: 32'h8000_0200,
              badvaddr: 32'h0, target: 32'h8000_3000};
        launch(e, 3);

        // Interrupt beats a simultaneous overflow
        bus.cp0_status   = 32'h0000_0401;
        bus.cp0_cause    = 32'h0000_0400;
        bus.mem_valid    = 1'b1;
        bus.mem_ex       = 1'b1;
        bus.mem_excode   = 5'h0c;
        bus.mem_eret     = 1'b1;
        bus.mem_pc       = 32'h8000_4000;
        bus.mem_badvaddr = 32'h1234_5678;
        e = '{excode: 5'h00, bd: 1'b0, eret: 1'b0, epc: 32'h8000_4000,
              badvaddr: 32'h1234_5678, target: 32'h8000_0180};
        launch(e, 3);

        // Pending interrupt without a valid instruction is held off
        bus.cp0_status = 32'h0000_0401;
        bus.cp0_cause  = 32'h0000_0400;
        @(negedge clk);
        chk("novalid_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;

        // Same-cycle Status write defers the interrupt by one cycle
        bus.mem_valid     = 1'b1;
        bus.mem_pc        = 32'h8000_5000;
        bus.mem_mtc0      = 1'b1;
        bus.mem_mtc0_addr = 8'h60;
        @(negedge clk);
        chk("mtc0_block_stall", {31'd0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        chk("mtc0_block_ex", {31'd0, bus.ex_valid}, 32'd0);
        bus.mem_mtc0  = 1'b0;
        bus.mem_pc    = 32'h8000_5004;
        e = '{excode: 5'h00, bd: 1'b0, eret: 1'b0, epc: 32'h8000_5004,
              badvaddr: 32'h0, target: 32'h8000_0180};
        launch(e, 3);

        // Drain: busy on the take cycle plus two more
        bus.mem_valid  = 1'b1;
        bus.mem_ex     = 1'b1;
        bus.mem_excode = 5'h05;
        bus.mem_pc     = 32'h8000_6000;
        bus.mem_busy   = 1'b1;
        bus.cp0_status = 32'h0040_0000;
        e = '{excode: 5'h05, bd: 1'b0, eret: 1'b0, epc: 32'h8000_6000,
              badvaddr: 32'h0, target: 32'hBFC0_0380};
        exq.push_back(e);
        rdq.push_back(e.target);
        @(negedge clk);
        chk("drain_take_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        clear_inputs();
        bus.mem_busy = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("drain_stall", {31'd0, bus.stall}, 32'd1);
            chk("drain_no_ex", {31'd0, bus.ex_valid}, 32'd0);
            @(posedge clk); #1;
        end
        bus.mem_busy = 1'b0;
        @(negedge clk);
        chk("drain_last_stall", {31'd0, bus.stall}, 32'd1);
        chk("drain_last_no_ex", {31'd0, bus.ex_valid}, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Reset while draining
        bus.mem_valid = 1'b1;
        bus.mem_ex    = 1'b1;
        bus.mem_pc    = 32'h8000_7000;
        bus.mem_busy  = 1'b1;
        @(negedge clk);
        chk("rstd_take_stall", {31'd0, bus.stall}, 32'd1);
        @(posedge clk); #1;
        bus.mem_valid = 1'b0;
        bus.mem_ex    = 1'b0;
        @(negedge clk);
        chk("rstd_drain_stall", {31'd0, bus.stall}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rstd_stall", {31'd0, bus.stall}, 32'd0);
        chk("rstd_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("rstd_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        @(posedge clk); #1;
        resetn       = 1'b1;
        bus.mem_busy = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        chk("exq_left", exq.size(), 32'd0);
        chk("rdq_left", rdq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Exception/interrupt commit controller between the MEM stage and the cp0 register block.
- Samples pending interrupts from cp0 Cause/Status and arbitrates them against the exception or eret carried by the MEM-stage instruction.
- Waits for outstanding data-bus transactions to drain, then pulses the cp0 exception interface once.
- Finally flushes the pipeline and redirects fetch to the handler entry or to EPC.

Parameters:
- ENTRY_BEV1, 32'hBFC00380, handler entry when Status.BEV=1
- ENTRY_BEV0, 32'h80000180, handler entry when Status.BEV=0
- EXC_INT, 5'h00, ExcCode written for interrupts

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- mem_valid  in  1  MEM stage holds a valid instruction
- mem_pc  in  32  PC of MEM instruction
- mem_bd  in  1  MEM instruction is in a branch delay slot
- mem_ex  in  1  MEM instruction carries a synchronous exception
- mem_excode  in  5  its exception code
- mem_badvaddr  in  32  its faulting address
- mem_eret  in  1  MEM instruction is eret
- mem_mtc0  in  1  MEM instruction writes cp0 this cycle
- mem_mtc0_addr  in  8  cp0 address being written
- mem_busy  in  1  data bus has outstanding transactions
- cp0_status  in  32  Status from cp0
- cp0_cause  in  32  Cause from cp0
- cp0_epc  in  32  EPC from cp0
- ex_valid  out  1  one-cycle exception/eret commit pulse to cp0
- ex_excode  out  5  to cp0
- ex_bd  out  1  to cp0
- ex_epc  out  32  to cp0
- ex_badvaddr  out  32  to cp0
- ex_eret  out  1  to cp0
- stall  out  1  freeze pipeline
- flush  out  1  kill all stages younger than and including MEM
- redirect_valid  out  1  fetch redirect strobe
- redirect_pc  out  32  redirect target

Behaviour:
- Reset: state=IDLE; every output 0; all capture registers 0.
- int_req = |(cp0_cause[15:8] & cp0_status[15:8]) & cp0_status[0] & !cp0_status[1] & !int_block.
- int_block = mem_mtc0 & (mem_mtc0_addr==Status | mem_mtc0_addr==Cause). A same-cycle Status/Cause write defers the interrupt by one cycle.
- take = (state==IDLE) & mem_valid & (int_req | mem_ex | mem_eret).
- Priority: interrupt > mem_ex > mem_eret.
- On take, capture into registers:
  - excode: EXC_INT, or mem_excode.
  - eret flag: set only when no interrupt and no mem_ex.
  - bd: mem_bd.
  - epc: mem_bd ? mem_pc-4 : mem_pc (mod 2^32).
  - badvaddr: mem_badvaddr.
  - target: EPC if eret, else the BEV-selected entry. cp0_epc is latched at take; the BEV entry is selected from cp0_status[22] at take.
- stall is combinational high on the take cycle and in DRAIN and COMMIT.
- States:
  - IDLE: on take → DRAIN if mem_busy, else COMMIT.
  - DRAIN: stay while mem_busy; → COMMIT when mem_busy=0. There is no timeout.
  - COMMIT: ex_valid=1 with captured fields for exactly one cycle → REDIRECT.
  - REDIRECT: flush=1, redirect_valid=1, redirect_pc=target for one cycle → IDLE.
- Minimum latency: take at T, ex_valid at T+1, flush/redirect at T+2, next take possible at T+3.
- ex_* outputs are 0 outside COMMIT. flush/redirect are 0 outside REDIRECT.
- Events at mem_* while state≠IDLE are ignored; the pipeline is stalled or being flushed.
- mem_valid=0 blocks take even with int_req=1: the interrupt waits for a valid instruction.
- Async reset mid-sequence returns to IDLE immediately. No partial ex_valid is ever emitted after reset deassertion.

Decomposition:
- Shared package: cp0 address constants (Status, Cause, EPC), ExcCode constants (INT, AdEL, AdES, Sys, Bp, RI, Ov), Status/Cause bit-field indices, FSM state encoding (IDLE, DRAIN, COMMIT, REDIRECT).
- One natural sub-module, exc_prio: combinational int_req/int_block/priority select producing take, excode, eret flag. The FSM and capture registers stay in exc_ctrl.

Test Plan:
- Interrupt path: Status=32'h0040_0401, Cause[10]=1, mem_valid=1, mem_pc=32'h8000_1000, mem_bd=0, mem_busy=0 → T+1 ex_valid=1, ex_excode=0, ex_epc=32'h8000_1000; T+2 redirect_pc=32'hBFC0_0380, flush=1.
- AdEL in delay slot, BEV=0: mem_ex=1, mem_excode=5'h04, mem_pc=32'h8000_2004, mem_bd=1, badvaddr=32'h0000_0003 → ex_epc=32'h8000_2000, ex_bd=1, ex_badvaddr=32'h3; redirect_pc=32'h8000_0180.
- eret: mem_eret=1, cp0_epc=32'h8000_3000, no interrupt → ex_valid=1 with ex_eret=1; redirect_pc=32'h8000_3000.
- Drain: take with mem_busy=1 for 3 cycles → stall=1 throughout, ex_valid only the cycle after mem_busy falls, exactly once.
- Interrupt and mem_ex together → ex_excode=0. With mem_mtc0 to Status in the same cycle → no take; take occurs next cycle.
- Reset asserted during DRAIN → all outputs 0 immediately. After release, no ex_valid or redirect until a new take.
